// File: rtl/riscv_defines.sv
// ----------------------------------------------------------------------------
// riscv_defines
//   Shared definitions for the RISC-V memory subsystem.
//   - RISCV_ADDR_WIDTH / RISCV_WORD_WIDTH : bus address and data widths
//   - RISCV_BE_WIDTH                      : byte enables per data word
//   - ctrl_state_e                        : mp_ram access controller states
//   - idx_width()                         : width of a port index, never zero
// ----------------------------------------------------------------------------
package riscv_defines;

  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;
  localparam int RISCV_BE_WIDTH   = RISCV_WORD_WIDTH / 8;

  // Access controller: IDLE arbitrates, WAIT burns the configured latency,
  // ACK presents the completion strobe for exactly one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } ctrl_state_e;

  // A single-port build still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mp_ram_if.sv
// ----------------------------------------------------------------------------
// mp_ram_if
//   Per-port request/response bundle between requesters and mp_ram.
//   Each vector carries one lane per requester port.
//   - valid_i  : request held by the requester until ready_o
//   - ready_o  : one-cycle completion strobe
//   - addr_i   : byte address (bits [1:0] ignored by the RAM)
//   - wdata_i  : write data
//   - we_i     : byte write enables, all zero = read
//   - rdata_o  : read data, valid while ready_o is high, zero otherwise
//   master modport = requester side, slave modport = RAM side.
// ----------------------------------------------------------------------------
interface mp_ram_if #(
  parameter int NUM_PORTS = 2
);
  import riscv_defines::*;

  logic [NUM_PORTS-1:0]                       valid_i;
  logic [NUM_PORTS-1:0]                       ready_o;
  logic [NUM_PORTS-1:0][RISCV_ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS-1:0][RISCV_WORD_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS-1:0][RISCV_BE_WIDTH-1:0]   we_i;
  logic [NUM_PORTS-1:0][RISCV_WORD_WIDTH-1:0] rdata_o;

  modport master (
    output valid_i,
    output addr_i,
    output wdata_i,
    output we_i,
    input  ready_o,
    input  rdata_o
  );

  modport slave (
    input  valid_i,
    input  addr_i,
    input  wdata_i,
    input  we_i,
    output ready_o,
    output rdata_o
  );

endinterface

// File: rtl/mp_ram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin selector. The search starts at the port after
//   the last granted one and wraps modulo NUM_PORTS, so a port that was just
//   served has the lowest priority on the next decision.
//   Ports:
//   - req_i  : request vector
//   - last_i : index of the last granted port
//   - gnt_o  : one-hot grant (all zero when nothing requests)
//   - idx_o  : index of the granted port (last_i when nothing requests)
//   - any_o  : at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk offsets 1..NUM_PORTS from the last winner; the final offset lands
  // back on last_i itself, so a lone requester is always served.
  always_comb begin
    gnt_o = '0;
    idx_o = last_i;
    found = 1'b0;
    cand  = last_i;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = IDX_W'((int'(last_i) + off) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/mp_ram.sv
// ----------------------------------------------------------------------------
// mp_ram
//   Multi-port word RAM: NUM_PORTS requesters share one storage array that
//   performs at most one access per cycle. A round-robin arbiter picks the
//   next port, an optional LATENCY wait is counted off, and the access takes
//   effect on the edge that enters ACK (old word captured, then the enabled
//   bytes written). The granted port sees ready_o and rdata_o for one cycle.
//   Parameters:
//   - NUM_PORTS : requester count (1..8)
//   - DEPTH     : storage words, power of two; addresses wrap modulo DEPTH
//   - LATENCY   : extra wait cycles per access (0..15)
//   Ports:
//   - clk : clock, all state on the rising edge
//   - rst : asynchronous active-high reset (storage is not cleared)
//   - bus : mp_ram_if slave side (valid/ready/addr/wdata/we/rdata per port)
//   The interface instance must be built with the same NUM_PORTS.
// ----------------------------------------------------------------------------
module mp_ram
  import riscv_defines::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 16384,
  parameter int LATENCY   = 0
) (
  input  logic     clk,
  input  logic     rst,
  mp_ram_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam int CNT_W = 4;
  localparam bit LAT0  = (LATENCY == 0);

  // Storage; deliberately reset-free so it can map onto block RAM.
  logic [RISCV_WORD_WIDTH-1:0] mem [DEPTH];

  ctrl_state_e                 state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [IDX_W-1:0]            gnt_q;
  logic [RISCV_WORD_WIDTH-1:0] rdata_q;
  logic [NUM_PORTS-1:0]        ready_q;

  logic [NUM_PORTS-1:0]        arb_gnt;
  logic [IDX_W-1:0]            arb_idx;
  logic                        arb_any;

  logic [IDX_W-1:0]            sel_idx;
  logic [NUM_PORTS-1:0]        sel_onehot;
  logic [AW-1:0]               sel_word;
  logic [RISCV_WORD_WIDTH-1:0] sel_wdata;
  logic [RISCV_BE_WIDTH-1:0]   sel_we;
  logic                        access_d;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req_i  (bus.valid_i),
    .last_i (gnt_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  // The port being served: with LATENCY=0 the access happens on the edge
  // leaving IDLE, so the fresh arbiter result is used; otherwise the port
  // latched at grant time.
  always_comb begin
    sel_onehot = '0;
    if (state_q == IDLE) begin
      sel_idx    = arb_idx;
      sel_onehot = arb_gnt;
    end else begin
      sel_idx             = gnt_q;
      sel_onehot[gnt_q]   = 1'b1;
    end
    sel_word  = bus.addr_i[sel_idx][2 +: AW];
    sel_wdata = bus.wdata_i[sel_idx];
    sel_we    = bus.we_i[sel_idx];

    // The access fires only if the granted request is still held on the
    // ACK-entry edge. Gating with rst keeps a reset coincident with that
    // edge from writing the array.
    access_d = 1'b0;
    if (!rst) begin
      if (state_q == IDLE && arb_any && LAT0) begin
        access_d = 1'b1;
      end else if (state_q == WAIT && bus.valid_i[gnt_q] && cnt_q == CNT_W'(1)) begin
        access_d = 1'b1;
      end
    end
  end

  // Controller with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= IDX_W'(NUM_PORTS - 1);
      rdata_q <= '0;
      ready_q <= '0;
    end else begin
      ready_q <= '0;
      if (access_d) begin
        // Read-before-write: the non-blocking read sees the pre-write word.
        rdata_q <= mem[sel_word];
        ready_q <= sel_onehot;
      end
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            gnt_q <= arb_idx;
            cnt_q <= CNT_W'(LATENCY);
            state_q <= LAT0 ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!bus.valid_i[gnt_q]) begin
            // Requester withdrew: abandon without touching storage.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(1)) begin
            state_q <= ACK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Byte-masked write port of the storage array.
  always_ff @(posedge clk) begin
    if (access_d) begin
      for (int b = 0; b < RISCV_BE_WIDTH; b++) begin
        if (sel_we[b]) begin
          mem[sel_word][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Only the port in ACK sees the captured word; everyone else reads zero.
  assign bus.ready_o = ready_q;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign bus.rdata_o[gi] = ready_q[gi] ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mp_ram.sv
module tb_mp_ram;
  import riscv_defines::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mp_ram_if #(.NUM_PORTS(2)) bus_a ();
  mp_ram_if #(.NUM_PORTS(2)) bus_b ();

  // A: zero latency, tiny depth (exercises address wrap).
  mp_ram #(.NUM_PORTS(2), .DEPTH(16), .LATENCY(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  // B: three wait cycles per access.
  mp_ram #(.NUM_PORTS(2), .DEPTH(64), .LATENCY(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Reference storage: plain word arrays indexed by byte address / 4 mod depth.
  logic [31:0] ref_a [16];
  logic [31:0] ref_b [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input bit b, input logic [31:0] addr);
    logic [31:0] wa;
    wa = addr >> 2;
    return b ? int'(wa % 64) : int'(wa % 16);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rdy(input bit b);
    return b ? 32'(bus_b.ready_o) : 32'(bus_a.ready_o);
  endfunction

  function automatic logic [31:0] rd(input bit b, input int p);
    return b ? bus_b.rdata_o[p] : bus_a.rdata_o[p];
  endfunction

  task automatic drive(input bit b, input int p, input logic v, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] we);
    if (b) begin
      bus_b.valid_i[p] = v; bus_b.addr_i[p] = addr; bus_b.wdata_i[p] = wd; bus_b.we_i[p] = we;
    end else begin
      bus_a.valid_i[p] = v; bus_a.addr_i[p] = addr; bus_a.wdata_i[p] = wd; bus_a.we_i[p] = we;
    end
  endtask

  // One single-requester access: latency, strobe, data, other port quiet,
  // strobe lasts exactly one cycle. Returns the observed read data.
  task automatic xact(input bit b, input int p, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] we, input string tag, output logic [31:0] got);
    int n;
    int w;
    int lat;
    logic [31:0] exp;
    n   = 0;
    lat = b ? 3 : 0;
    w   = widx(b, addr);
    exp = b ? ref_b[w] : ref_a[w];
    @(posedge clk); #1;
    drive(b, p, 1'b1, addr, wd, we);
    do begin
      @(negedge clk);
      n++;
    end while (rdy(b) == 0 && n < 40);
    got = rd(b, p);
    chk({tag, "_lat"}, n, lat + 2);
    chk({tag, "_rdy"}, rdy(b), 32'(1 << p));
    chk({tag, "_rd"}, got, exp);
    chk({tag, "_other"}, rd(b, 1 - p), 32'h0);
    $display("xact %s dut=%0s port=%0d addr=%h we=%h wd=%h rd=%h lat=%0d",
             tag, b ? "B" : "A", p, addr, we, wd, got, n);
    if (b) ref_b[w] = merge(exp, wd, we);
    else   ref_a[w] = merge(exp, wd, we);
    @(posedge clk); #1;
    drive(b, p, 1'b0, addr, wd, we);
    @(negedge clk);
    chk({tag, "_one"}, rdy(b), 32'h0);
  endtask

  logic [31:0] got;
  logic [31:0] addr;
  logic [31:0] old;
  logic [31:0] aa [2];
  logic [3:0]  we;
  logic        anyr;
  int          exp_p;
  int          n;

  initial begin
    rst = 1'b1;
    bus_a.valid_i = '0; bus_a.addr_i = '0; bus_a.wdata_i = '0; bus_a.we_i = '0;
    bus_b.valid_i = '0; bus_b.addr_i = '0; bus_b.wdata_i = '0; bus_b.we_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_a", rdy(0), 32'h0);
    chk("rst_rd_a0", rd(0, 0), 32'h0);
    chk("rst_rd_a1", rd(0, 1), 32'h0);
    chk("rst_rdy_b", rdy(1), 32'h0);
    chk("rst_rd_b0", rd(1, 0), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Give every word a known value so later reads are predictable.
    for (int w = 0; w < 16; w++) begin
      xact(0, w % 2, 32'(w * 4), $urandom, 4'hF, "init_a", got);
      ref_a[w] = ref_a[w];
    end
    for (int w = 0; w < 64; w++) xact(1, w % 2, 32'(w * 4), $urandom, 4'hF, "init_b", got);

    // Full write then read back.
    xact(0, 0, 32'h10, 32'hDEADBEEF, 4'hF, "wr10", got);
    xact(0, 0, 32'h10, 32'h0, 4'h0, "rd10", got);
    chk("rd10_val", got, 32'hDEADBEEF);

    // Partial byte write.
    xact(0, 0, 32'h20, 32'h11223344, 4'hF, "wr20", got);
    xact(0, 1, 32'h20, 32'h0000AA00, 4'b0010, "wr20b", got);
    xact(0, 0, 32'h20, 32'h0, 4'h0, "rd20", got);
    chk("rd20_val", got, 32'h1122AA44);

    // Address wrap at DEPTH=16.
    xact(0, 1, 32'h40, 32'hCAFE0000, 4'hF, "wr40", got);
    xact(0, 0, 32'h00, 32'h0, 4'h0, "rd00", got);
    chk("wrap_val", got, 32'hCAFE0000);

    // Reset, then both ports request continuously: strict alternation from 0.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    aa[0] = $urandom;
    aa[1] = $urandom;
    exp_p = 1;
    @(posedge clk); #1;
    drive(0, 0, 1'b1, aa[0], 32'h0, 4'h0);
    drive(0, 1, 1'b1, aa[1], 32'h0, 4'h0);
    for (int g = 0; g < 6; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (rdy(0) == 0 && n < 20);
      exp_p = (exp_p + 1) % 2;
      chk("rr_gap", n, 2);
      chk("rr_grant", rdy(0), 32'(1 << exp_p));
      chk("rr_rd", rd(0, exp_p), ref_a[widx(0, aa[exp_p])]);
      $display("rr grant=%h want_port=%0d rd=%h", rdy(0), exp_p, rd(0, exp_p));
    end
    @(posedge clk); #1;
    drive(0, 0, 1'b0, aa[0], 32'h0, 4'h0);
    drive(0, 1, 1'b0, aa[1], 32'h0, 4'h0);
    @(negedge clk);
    chk("rr_idle", rdy(0), 32'h0);

    // Random single-requester traffic on A.
    for (int i = 0; i < 30; i++) begin
      we = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      xact(0, $urandom_range(0, 1), $urandom, $urandom, we, "rnd_a", got);
    end

    // Latency-3 directed write / read.
    xact(1, 0, 32'h84, 32'h5A5A1234, 4'hF, "wr84", got);
    xact(1, 1, 32'h84, 32'h0, 4'h0, "rd84", got);
    chk("rd84_val", got, 32'h5A5A1234);

    // Drop valid while waiting: no strobe, no write, next access on time.
    addr = $urandom;
    old  = ref_b[widx(1, addr)];
    @(posedge clk); #1; drive(1, 0, 1'b1, addr, ~old, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1; drive(1, 0, 1'b0, addr, ~old, 4'hF);
    anyr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      anyr = anyr | (rdy(1) != 0);
    end
    chk("drop_noack", 32'(anyr), 32'h0);
    $display("drop addr=%h strobe_seen=%0d", addr, anyr);
    xact(1, 0, addr, 32'h0, 4'h0, "drop_rd", got);
    chk("drop_keep", got, old);

    // Reset while waiting: same outcome.
    addr = $urandom;
    old  = ref_b[widx(1, addr)];
    @(posedge clk); #1; drive(1, 1, 1'b1, addr, ~old, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1; drive(1, 1, 1'b0, addr, ~old, 4'hF);
    #1;
    chk("rstw_rdy", rdy(1), 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    anyr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      anyr = anyr | (rdy(1) != 0);
    end
    chk("rstw_noack", 32'(anyr), 32'h0);
    $display("rst_wait addr=%h strobe_seen=%0d", addr, anyr);
    xact(1, 1, addr, 32'h0, 4'h0, "rstw_rd", got);
    chk("rstw_keep", got, old);

    // Random traffic on B.
    for (int i = 0; i < 20; i++) begin
      we = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      xact(1, $urandom_range(0, 1), $urandom, $urandom, we, "rnd_b", got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mp_ram.md
MP_RAM -- requirements
Module: mp_ram

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requester ports (1..8).
REQ-002 SHALL have parameter DEPTH, default 16384, storage size in 32-bit words (power of two).
REQ-003 SHALL have parameter LATENCY, default 0, extra wait cycles per access (0..15).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port valid_i  input  NUM_PORTS  per-port request.
REQ-007 SHALL have port ready_o  output  NUM_PORTS  per-port completion strobe.
REQ-008 SHALL have port addr_i  input  NUM_PORTS x RISCV_ADDR_WIDTH  per-port byte address.
REQ-009 SHALL have port wdata_i  input  NUM_PORTS x RISCV_WORD_WIDTH  per-port write data.
REQ-010 SHALL have port we_i  input  NUM_PORTS x 4  per-port byte write enables; all zero means read.
REQ-011 SHALL have port rdata_o  output  NUM_PORTS x RISCV_WORD_WIDTH  per-port read data.

Function
REQ-012 SHALL hold one storage array; at most one access per cycle across all ports.
REQ-013 SHALL run a controller with states IDLE, WAIT, ACK.
REQ-014 IDLE with any valid_i set: grant one port round-robin, starting search at last granted + 1 modulo NUM_PORTS; load counter with LATENCY; go to WAIT if LATENCY>0, else ACK.
REQ-015 IDLE with no valid_i: stay IDLE; granted index unchanged.
REQ-016 WAIT: decrement counter each cycle; on counter==1 go to ACK.
REQ-017 On the edge entering ACK: capture mem[word] into read register (read-before-write), then apply wdata_i bytes where we_i bit set; word = addr_i[2 +: log2(DEPTH)], higher bits ignored (address wraps modulo DEPTH words).
REQ-018 ACK: ready_o[granted]=1 for exactly one cycle, rdata_o[granted]=captured word; next state IDLE.
REQ-019 Timing: valid first seen in IDLE at cycle T -> ready_o at T+1+LATENCY; throughput one access per LATENCY+2 cycles.
REQ-020 Requester SHALL hold valid_i, addr_i, wdata_i, we_i stable until ready_o; if granted valid_i drops in WAIT or at ACK entry, go to IDLE, no access, no ready_o.
REQ-021 ready_o SHALL be 0 and rdata_o SHALL be 0 for every port not in ACK.
REQ-022 Valid on a non-granted port SHALL be ignored until controller returns to IDLE; no request lost while held.

Reset
REQ-023 On rst: state IDLE, counter 0, last-granted = NUM_PORTS-1 (port 0 wins first), read register 0, all ready_o and rdata_o 0.
REQ-024 Reset during WAIT or ACK SHALL abort the access with no write; storage contents are not reset.

Structure
REQ-025 RISCV_ADDR_WIDTH, RISCV_WORD_WIDTH and the controller state enum SHALL live in the shared riscv_defines package.
REQ-026 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, last-grant in, one-hot grant and index out).

Verification
REQ-027 LATENCY=0: port0 write 0x10, 0xDEADBEEF, we=4'hF, then read 0x10 -> each ready_o one cycle after valid; read returns 0xDEADBEEF.
REQ-028 Write 0x11223344 to 0x20, then wdata 0x0000AA00 we=4'b0010 -> read 0x20 returns 0x1122AA44.
REQ-029 After reset, ports 0 and 1 both continuously valid -> grants 0,1,0,1; no back-to-back repeat while both request.
REQ-030 LATENCY=3: valid in IDLE at cycle T -> ready_o at T+4 exactly; no ready_o in T+1..T+3.
REQ-031 DEPTH=16: write 0xCAFE0000 to 0x40 -> read 0x00 returns 0xCAFE0000.
REQ-032 LATENCY=3: drop valid_i or assert rst during WAIT -> no ready_o, target word unchanged, controller IDLE next cycle.
